// File: rtl/seq_bit_serializer.sv
// ---------------------------------------------------------------------------
// seq_bit_serializer
//   Parallel-to-serial front end for the serial sequence detector. Words of
//   WIDTH bits are taken over a valid/ready handshake and shifted out one bit
//   at a time on x, each bit held for DIV clock cycles. Consecutive words
//   stream with no idle gap when the next word is offered on the last cycle
//   of the current word.
//
// Ports
//   clk        in   1      system clock, rising edge
//   rst        in   1      asynchronous, active-low reset
//   din        in   WIDTH  word to serialize, sampled only on handshake
//   din_valid  in   1      din holds a word
//   din_ready  out  1      block can take a word this cycle (combinational)
//   x          out  1      serial bit stream (registered)
//   x_valid    out  1      x carries a data bit (registered)
//   busy       out  1      a word is in flight
//   word_done  out  1      one-cycle pulse after the last bit of a word
// ---------------------------------------------------------------------------
module seq_bit_serializer #(
    parameter int WIDTH     = 8,
    parameter bit MSB_FIRST = 1'b1,
    parameter int DIV       = 1,
    parameter bit IDLE_BIT  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    input  logic             din_valid,
    output logic             din_ready,
    output logic             x,
    output logic             x_valid,
    output logic             busy,
    output logic             word_done
);

    localparam int BW = $clog2(WIDTH);
    localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [BW-1:0] BCNT_LAST = BW'(WIDTH - 1);
    localparam logic [BW-1:0] BCNT_ONE  = BW'(1);
    localparam logic [BW-1:0] BCNT_ZERO = BW'(0);
    localparam logic [DW-1:0] DCNT_LAST = DW'(DIV - 1);
    localparam logic [DW-1:0] DCNT_ONE  = DW'(1);
    localparam logic [DW-1:0] DCNT_ZERO = DW'(0);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [0:0]       state_r;
    logic [WIDTH-1:0] shreg_r;
    logic [BW-1:0]    bcnt_r;
    logic [DW-1:0]    dcnt_r;
    logic             x_r;
    logic             x_valid_r;
    logic             word_done_r;

    logic             bit_end_s;
    logic             last_s;
    logic             din_ready_s;
    logic             accept_s;

    // Bit that goes on the line first for a freshly loaded word.
    function automatic logic head_bit(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? w[WIDTH-1] : w[0];
    endfunction

    // Word with its head bit removed, so head_bit() yields the next one.
    function automatic logic [WIDTH-1:0] drop_head(input logic [WIDTH-1:0] w);
        return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
    endfunction

    // Bit/word boundary detection and ready generation.
    always_comb begin
        bit_end_s   = 1'b0;
        last_s      = 1'b0;
        din_ready_s = 1'b0;
        if (state_r == ST_SHIFT) begin
            bit_end_s = (dcnt_r == DCNT_LAST);
            last_s    = bit_end_s && (bcnt_r == BCNT_LAST);
        end else begin
            bit_end_s = 1'b0;
            last_s    = 1'b0;
        end
        // Ready is held low while reset is asserted, without waiting for a clock.
        if (!rst) begin
            din_ready_s = 1'b0;
        end else if (state_r == ST_IDLE) begin
            din_ready_s = 1'b1;
        end else begin
            din_ready_s = last_s;
        end
    end

    assign accept_s = din_valid & din_ready_s;

    // Sequencer: loads words, paces bits by DIV and chains words gaplessly.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_IDLE;
            shreg_r     <= '0;
            bcnt_r      <= BCNT_ZERO;
            dcnt_r      <= DCNT_ZERO;
            x_r         <= IDLE_BIT;
            x_valid_r   <= 1'b0;
            word_done_r <= 1'b0;
        end else begin
            word_done_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_r   <= ST_SHIFT;
                        shreg_r   <= drop_head(din);
                        x_r       <= head_bit(din);
                        x_valid_r <= 1'b1;
                        bcnt_r    <= BCNT_ZERO;
                        dcnt_r    <= DCNT_ZERO;
                    end else begin
                        x_r       <= IDLE_BIT;
                        x_valid_r <= 1'b0;
                    end
                end
                ST_SHIFT: begin
                    if (last_s) begin
                        word_done_r <= 1'b1;
                        bcnt_r      <= BCNT_ZERO;
                        dcnt_r      <= DCNT_ZERO;
                        if (accept_s) begin
                            // Next word follows on the very next cycle.
                            shreg_r   <= drop_head(din);
                            x_r       <= head_bit(din);
                            x_valid_r <= 1'b1;
                        end else begin
                            state_r   <= ST_IDLE;
                            shreg_r   <= '0;
                            x_r       <= IDLE_BIT;
                            x_valid_r <= 1'b0;
                        end
                    end else if (bit_end_s) begin
                        dcnt_r  <= DCNT_ZERO;
                        bcnt_r  <= bcnt_r + BCNT_ONE;
                        x_r     <= head_bit(shreg_r);
                        shreg_r <= drop_head(shreg_r);
                    end else begin
                        dcnt_r <= dcnt_r + DCNT_ONE;
                    end
                end
                default: begin
                    state_r   <= ST_IDLE;
                    shreg_r   <= '0;
                    bcnt_r    <= BCNT_ZERO;
                    dcnt_r    <= DCNT_ZERO;
                    x_r       <= IDLE_BIT;
                    x_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign din_ready = din_ready_s;
    assign x         = x_r;
    assign x_valid   = x_valid_r;
    assign busy      = (state_r == ST_SHIFT);
    assign word_done = word_done_r;

endmodule
